// File: rtl/mc_pkg.sv
// mc_pkg: shared encodings and defaults for the multicycle RV32I datapath
package mc_pkg;
  localparam int XLEN_DEF = 32;
  typedef enum logic [6:0] {
    OP_LW   = 7'b0000011,
    OP_I    = 7'b0010011,
    OP_SW   = 7'b0100011,
    OP_R    = 7'b0110011,
    OP_BEQ  = 7'b1100011,
    OP_JAL  = 7'b1101111
  } opcodetype;
  typedef enum logic [1:0] {IMM_I, IMM_S, IMM_B, IMM_J} imm_src_t;
  typedef enum logic [1:0] {SRCA_PC, SRCA_OLDPC, SRCA_A, SRCA_ZERO} alu_src_a_t;
  typedef enum logic [1:0] {SRCB_B, SRCB_IMM, SRCB_FOUR, SRCB_ZERO} alu_src_b_t;
  typedef enum logic [1:0] {RES_ALUOUT, RES_DATA, RES_ALURESULT, RES_ZERO} result_src_t;
  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_ctrl_t;
endpackage

// File: rtl/mc_alu.sv
// mc_alu: add/sub/and/or/slt on a, b selected by ctrl -> y; unlisted codes give 0
module mc_alu
  import mc_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [2:0]      ctrl,
  output logic [XLEN-1:0] y
);
  always_comb
    y = ctrl == ALU_ADD ? a + b :
        ctrl == ALU_SUB ? a - b :
        ctrl == ALU_AND ? a & b :
        ctrl == ALU_OR  ? a | b :
        ctrl == ALU_SLT ? {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)} : '0;
endmodule

// File: rtl/mc_regfile.sv
// mc_regfile: 32xXLEN register file (clk, rst sync clear, we/a3/wd write, a1/a2 -> rd1/rd2 async read, x0 hardwired)
module mc_regfile
  import mc_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [4:0]      a1,
  input  logic [4:0]      a2,
  input  logic [4:0]      a3,
  input  logic [XLEN-1:0] wd,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2
);
  logic [XLEN-1:0] rf [32];
  always_ff @(posedge clk)
    if (rst) for (int i = 0; i < 32; i++) rf[i] <= '0;
    else if (we && a3 != 5'd0) rf[a3] <= wd;
  assign rd1 = a1 == 5'd0 ? '0 : rf[a1];
  assign rd2 = a2 == 5'd0 ? '0 : rf[a2];
endmodule

// File: rtl/mc_datapath.sv
// mc_datapath: multicycle RV32I datapath (controls in, ReadData in; Adr/WriteData to memory, op/funct3/funct7b5/Zero to controller)
module mc_datapath
  import mc_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [1:0]      ImmSrc,
  input  logic [1:0]      ALUSrcA,
  input  logic [1:0]      ALUSrcB,
  input  logic [1:0]      ResultSrc,
  input  logic            AdrSrc,
  input  logic [2:0]      ALUControl,
  input  logic            IRWrite,
  input  logic            PCWrite,
  input  logic            RegWrite,
  input  logic [XLEN-1:0] ReadData,
  output logic [XLEN-1:0] Adr,
  output logic [XLEN-1:0] WriteData,
  output logic [6:0]      op,
  output logic [2:0]      funct3,
  output logic            funct7b5,
  output logic            Zero
);
  logic [XLEN-1:0] pc, old_pc, data, a, b, alu_out, rd1, rd2, imm_ext, src_a, src_b, alu_result, result;
  logic [31:0] instr;
  always_ff @(posedge clk)
    if (reset) begin
      pc      <= RESET_PC;
      old_pc  <= '0;
      instr   <= '0;
      data    <= '0;
      a       <= '0;
      b       <= '0;
      alu_out <= '0;
    end else begin
      if (PCWrite) pc <= result;
      if (IRWrite) begin
        instr  <= ReadData[31:0];
        old_pc <= pc;
      end
      data    <= ReadData;
      a       <= rd1;
      b       <= rd2;
      alu_out <= alu_result;
    end
  mc_regfile #(.XLEN(XLEN)) u_rf (
    .clk(clk), .rst(reset), .we(RegWrite),
    .a1(instr[19:15]), .a2(instr[24:20]), .a3(instr[11:7]),
    .wd(result), .rd1(rd1), .rd2(rd2)
  );
  always_comb
    imm_ext = ImmSrc == IMM_I ? {{(XLEN-12){instr[31]}}, instr[31:20]} :
              ImmSrc == IMM_S ? {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]} :
              ImmSrc == IMM_B ? {{(XLEN-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0} :
                                {{(XLEN-20){instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
  always_comb begin
    src_a = ALUSrcA == SRCA_PC ? pc : ALUSrcA == SRCA_OLDPC ? old_pc : ALUSrcA == SRCA_A ? a : '0;
    src_b = ALUSrcB == SRCB_B ? b : ALUSrcB == SRCB_IMM ? imm_ext : ALUSrcB == SRCB_FOUR ? XLEN'(4) : '0;
  end
  mc_alu #(.XLEN(XLEN)) u_alu (.a(src_a), .b(src_b), .ctrl(ALUControl), .y(alu_result));
  always_comb
    result = ResultSrc == RES_ALUOUT ? alu_out : ResultSrc == RES_DATA ? data :
             ResultSrc == RES_ALURESULT ? alu_result : '0;
  assign Adr       = AdrSrc ? result : pc;
  assign WriteData = b;
  assign op        = instr[6:0];
  assign funct3    = instr[14:12];
  assign funct7b5  = instr[30];
  assign Zero      = alu_result == '0;
endmodule

// File: tb/tb_mc_datapath.sv
// tb_mc_datapath: scoreboard bench for mc_datapath, directed program plus randomized control/data cycles
module tb_mc_datapath;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [1:0] ImmSrc = '0, ALUSrcA = '0, ALUSrcB = '0, ResultSrc = '0;
  logic AdrSrc = 1'b0, IRWrite = 1'b0, PCWrite = 1'b0, RegWrite = 1'b0;
  logic [2:0] ALUControl = '0;
  logic [31:0] ReadData = '0, Adr, WriteData;
  logic [6:0] op;
  logic [2:0] funct3;
  logic funct7b5, Zero;
  mc_datapath #(.XLEN(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .ImmSrc(ImmSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ResultSrc(ResultSrc), .AdrSrc(AdrSrc), .ALUControl(ALUControl), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .RegWrite(RegWrite), .ReadData(ReadData), .Adr(Adr),
    .WriteData(WriteData), .op(op), .funct3(funct3), .funct7b5(funct7b5), .Zero(Zero)
  );
  always #5 clk = ~clk;
  typedef struct {
    string       tag;
    logic [5:0]  m;
    logic [31:0] adr, wd;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7, z;
  } exp_t;
  exp_t q[$];
  int compared = 0, mismatched = 0;
  bit on = 1'b0;
  logic [31:0] m_pc, m_old, m_ir, m_data, m_a, m_b, m_out, e_alu, e_res;
  logic [31:0] m_rf [32];
  task automatic chk(string n, logic [31:0] got, logic [31:0] want_v);
    compared++;
    if (got !== want_v) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h", n, got, want_v);
    end
  endtask
  always @(negedge clk)
    while (q.size() > 0) begin : mon
      exp_t e;
      e = q.pop_front();
      if (e.m[0]) chk({e.tag, ".Adr"}, Adr, e.adr);
      if (e.m[1]) chk({e.tag, ".WriteData"}, WriteData, e.wd);
      if (e.m[2]) chk({e.tag, ".op"}, 32'(op), 32'(e.op));
      if (e.m[3]) chk({e.tag, ".funct3"}, 32'(funct3), 32'(e.f3));
      if (e.m[4]) chk({e.tag, ".funct7b5"}, 32'(funct7b5), 32'(e.f7));
      if (e.m[5]) chk({e.tag, ".Zero"}, 32'(Zero), 32'(e.z));
    end
  function automatic logic [31:0] imm(logic [31:0] i, logic [1:0] s);
    case (s)
      2'd0:    return 32'($signed(i[31:20]));
      2'd1:    return 32'($signed({i[31:25], i[11:7]}));
      2'd2:    return 32'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
      default: return 32'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
    endcase
  endfunction
  task automatic model_eval(output exp_t e);
    logic [31:0] x, y;
    case (ALUSrcA)
      2'd0: x = m_pc;
      2'd1: x = m_old;
      2'd2: x = m_a;
      default: x = 0;
    endcase
    case (ALUSrcB)
      2'd0: y = m_b;
      2'd1: y = imm(m_ir, ImmSrc);
      2'd2: y = 4;
      default: y = 0;
    endcase
    case (ALUControl)
      3'd0: e_alu = x + y;
      3'd1: e_alu = x - y;
      3'd2: e_alu = x & y;
      3'd3: e_alu = x | y;
      3'd5: e_alu = (int'(x) < int'(y)) ? 32'd1 : 32'd0;
      default: e_alu = 0;
    endcase
    case (ResultSrc)
      2'd0: e_res = m_out;
      2'd1: e_res = m_data;
      2'd2: e_res = e_alu;
      default: e_res = 0;
    endcase
    e.m = 6'h3f;
    e.adr = AdrSrc ? e_res : m_pc;
    e.wd = m_b;
    e.op = m_ir[6:0];
    e.f3 = m_ir[14:12];
    e.f7 = m_ir[30];
    e.z = e_alu == 0;
  endtask
  task automatic model_step();
    logic [31:0] r1, r2;
    if (reset) begin
      {m_pc, m_old, m_ir, m_data, m_a, m_b, m_out} = '0;
      foreach (m_rf[i]) m_rf[i] = 0;
    end else begin
      r1 = m_rf[m_ir[19:15]];
      r2 = m_rf[m_ir[24:20]];
      if (RegWrite && m_ir[11:7] != 0) m_rf[m_ir[11:7]] = e_res;
      if (IRWrite) begin
        m_old = m_pc;
        m_ir = ReadData;
      end
      if (PCWrite) m_pc = e_res;
      m_data = ReadData;
      m_a = r1;
      m_b = r2;
      m_out = e_alu;
    end
  endtask
  task automatic cyc(string t, bit r, logic [1:0] is, logic [1:0] sa, logic [1:0] sb, logic [1:0] rs,
                     bit as, logic [2:0] ac, bit iw, bit pw, bit rw, logic [31:0] d);
    exp_t e;
    reset = r; ImmSrc = is; ALUSrcA = sa; ALUSrcB = sb; ResultSrc = rs; AdrSrc = as;
    ALUControl = ac; IRWrite = iw; PCWrite = pw; RegWrite = rw; ReadData = d;
    model_eval(e);
    e.tag = t;
    if (on) q.push_back(e);
    @(posedge clk);
    model_step();
    #1;
  endtask
  task automatic want(string t, logic [5:0] m, logic [31:0] adr, logic [31:0] wd,
                      logic [6:0] o, logic [2:0] f, bit z);
    exp_t e;
    e.tag = t; e.m = m; e.adr = adr; e.wd = wd; e.op = o; e.f3 = f; e.f7 = 1'b0; e.z = z;
    q.push_back(e);
  endtask
  task automatic fetch(string t, logic [31:0] ins);
    cyc(t, 0, 0, 0, 2, 2, 0, 0, 1, 1, 0, ins);
  endtask
  task automatic dec(string t, logic [1:0] is);
    cyc(t, 0, is, 1, 1, 0, 0, 0, 0, 0, 0, $urandom);
  endtask
  task automatic exe(string t, logic [1:0] is, logic [1:0] sa, logic [1:0] sb, logic [2:0] ac);
    cyc(t, 0, is, sa, sb, 2, 1, ac, 0, 0, 0, $urandom);
  endtask
  task automatic wb(string t);
    cyc(t, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, $urandom);
  endtask
  task automatic addi(string t, logic [31:0] ins);
    fetch(t, ins);
    dec(t, 0);
    exe(t, 0, 2, 1, 0);
    wb(t);
  endtask
  task automatic rb(string t, logic [4:0] r, logic [31:0] v);
    fetch(t, {12'h0, r, 3'b0, 5'b0, 7'h13});
    dec(t, 0);
    want(t, 6'h01, v, 0, 0, 0, 0);
    exe(t, 0, 2, 3, 0);
  endtask
  initial begin
    cyc("rst", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    on = 1'b1;
    cyc("rst2", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    want("reset_out", 6'h1f, 32'h0, 32'h0, 7'h00, 3'd0, 0);
    fetch("fetch", 32'h0050_0093);
    want("fetch_res", 6'h0d, 32'h4, 0, 7'h13, 3'd0, 0);
    dec("addi_x1", 0);
    exe("addi_x1", 0, 2, 1, 0);
    wb("addi_x1");
    rb("read_x1", 1, 32'd5);
    addi("addi_x2", 32'h1000_0113);
    fetch("sw", 32'h0011_2423);
    dec("sw", 1);
    exe("sw_adr", 1, 2, 1, 0);
    want("sw_mem", 6'h03, 32'h108, 32'd5, 0, 0, 0);
    cyc("sw_mem", 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, $urandom);
    fetch("lw", 32'h0081_2203);
    dec("lw", 0);
    exe("lw_adr", 0, 2, 1, 0);
    want("lw_mem", 6'h01, 32'h108, 0, 0, 0, 0);
    cyc("lw_mem", 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 32'hDEAD_BEEF);
    cyc("lw_wb", 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, $urandom);
    rb("read_x4", 4, 32'hDEAD_BEEF);
    addi("addi_x3", 32'h0050_0193);
    addi("write_x0", 32'hFFF0_0013);
    fetch("beq", 32'hFE30_8CE3);
    dec("beq", 2);
    want("beq", 6'h21, 32'h18, 0, 0, 0, 1);
    cyc("beq", 0, 2, 2, 0, 0, 1, 1, 0, 1, 0, $urandom);
    want("branch_pc", 6'h01, 32'h18, 0, 0, 0, 0);
    rb("read_x0", 0, 32'h0);
    addi("addi_x5", 32'hFFF0_0293);
    addi("addi_x6", 32'h0010_0313);
    fetch("slt_lt", 32'h0062_A3B3);
    dec("slt_lt", 0);
    want("slt_lt", 6'h01, 32'h1, 0, 0, 0, 0);
    exe("slt_lt", 0, 2, 0, 5);
    fetch("slt_ge", 32'h0053_23B3);
    dec("slt_ge", 0);
    want("slt_ge", 6'h01, 32'h0, 0, 0, 0, 0);
    exe("slt_ge", 0, 2, 0, 5);
    fetch("rst_wb", 32'h0070_0413);
    dec("rst_wb", 0);
    exe("rst_wb", 0, 2, 1, 0);
    cyc("rst_wb", 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, $urandom);
    want("rst_wb_pc", 6'h01, 32'h0, 0, 0, 0, 0);
    rb("read_x8", 8, 32'h0);
    fetch("jal", 32'h0100_00EF);
    dec("jal", 3);
    cyc("jal", 0, 0, 1, 2, 0, 0, 0, 0, 1, 0, $urandom);
    wb("jal_wb");
    want("jal_pc", 6'h01, 32'h14, 0, 0, 0, 0);
    rb("read_x1_jal", 1, 32'h8);
    for (int i = 0; i < 800; i++)
      cyc("rand", $urandom_range(0, 39) == 0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
          2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
          3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), $urandom);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
